// File: rtl/bcd_preset_entry.sv
`default_nettype none
// ============================================================================
// Module   : bcd_preset_entry
// Purpose  : Button-driven editor that composes a two-digit BCD preset and
//            hands it to the stopwatch counter through a valid/ready
//            handshake. Provides digit-select and blink hints to the display.
//
// Ports    : clk          - system clock (only clock)
//            rst          - synchronous active-high reset
//            edit_btn     - enter edit mode / toggle ones<->tens (rise)
//            inc_btn      - increment selected digit (rise + auto-repeat)
//            dec_btn      - decrement selected digit (rise + auto-repeat)
//            enter_btn    - commit edited value (rise)
//            preset_ready - counter accepts the preset
//            preset[7:0]  - BCD value, [7:4] tens, [3:0] ones
//            preset_valid - preset is offered to the counter
//            editing      - high while a digit is being edited
//            digit_sel    - 0 = ones selected, 1 = tens selected
//            blink        - blank enable for the selected digit
//
// Options  : BCD_PRESET_BLINK_EN - when defined, blink toggles every
//            BLINK_CYCLES while editing; otherwise blink is tied low.
//
// Revision : 1.0 - initial release
// ============================================================================
module bcd_preset_entry #(
    parameter int HOLD_CYCLES   = 5_000_000,
    parameter int REPEAT_CYCLES = 1_000_000,
    parameter int BLINK_CYCLES  = 2_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       edit_btn,
    input  logic       inc_btn,
    input  logic       dec_btn,
    input  logic       enter_btn,
    input  logic       preset_ready,
    output logic [7:0] preset,
    output logic       preset_valid,
    output logic       editing,
    output logic       digit_sel,
    output logic       blink
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ONES   = 2'd1;
    localparam logic [1:0] c_ST_TENS   = 2'd2;
    localparam logic [1:0] c_ST_COMMIT = 2'd3;

    localparam int c_CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int c_CNT_W   = (c_CNT_MAX < 2) ? 1 : $clog2(c_CNT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_HOLD   = c_CNT_W'(HOLD_CYCLES);
    localparam logic [c_CNT_W-1:0] c_REPEAT = c_CNT_W'(REPEAT_CYCLES);

    // ------------------------------------------------------------------
    // BCD digit helpers: wrap within 0..9, never carry or borrow
    // ------------------------------------------------------------------
    function automatic logic [3:0] f_bcd_inc(input logic [3:0] d);
        return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic [3:0] f_bcd_dec(input logic [3:0] d);
        return (d == 4'd0) ? 4'd9 : d - 4'd1;
    endfunction

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic               r_edit_q;
    logic               r_inc_q;
    logic               r_dec_q;
    logic               r_enter_q;
    logic [7:0]         r_work;
    logic [7:0]         r_committed;
    logic [c_CNT_W-1:0] r_rpt_cnt;
    logic               r_rpt_phase;   // 0: waiting HOLD, 1: waiting REPEAT

    logic               w_edit_rise;
    logic               w_inc_rise;
    logic               w_dec_rise;
    logic               w_enter_rise;
    logic               w_in_edit;
    logic               w_state_chg;
    logic               w_hold_inc;
    logic               w_hold_dec;
    logic [c_CNT_W-1:0] w_cnt_inc;
    logic               w_rpt_fire;
    logic               w_step_inc;
    logic               w_step_dec;
    logic               w_handshake;
    logic [3:0]         w_sel_nib;

    // Rise = level sampled now is high, level registered last cycle is low
    assign w_edit_rise  = edit_btn  & ~r_edit_q;
    assign w_inc_rise   = inc_btn   & ~r_inc_q;
    assign w_dec_rise   = dec_btn   & ~r_dec_q;
    assign w_enter_rise = enter_btn & ~r_enter_q;

    assign w_in_edit   = (r_state == c_ST_ONES) || (r_state == c_ST_TENS);
    assign w_state_chg = (w_state_next != r_state);
    assign w_handshake = (r_state == c_ST_COMMIT) && preset_ready;

    // Auto-repeat only runs while exactly one of inc/dec is held past its rise
    assign w_hold_inc = inc_btn & r_inc_q & ~dec_btn;
    assign w_hold_dec = dec_btn & r_dec_q & ~inc_btn;
    assign w_cnt_inc  = r_rpt_cnt + c_CNT_W'(1);
    assign w_rpt_fire = (w_cnt_inc == (r_rpt_phase ? c_REPEAT : c_HOLD));

    // A cycle that changes state (digit toggle, commit, cancel) never steps
    assign w_step_inc = w_in_edit && !w_state_chg && !dec_btn &&
                        (w_inc_rise || (w_hold_inc && w_rpt_fire));
    assign w_step_dec = w_in_edit && !w_state_chg && !inc_btn &&
                        (w_dec_rise || (w_hold_dec && w_rpt_fire));

    assign w_sel_nib = (r_state == c_ST_TENS) ? r_work[7:4] : r_work[3:0];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_edit_rise) w_state_next = c_ST_ONES;
            end
            c_ST_ONES: begin
                if (w_edit_rise && w_enter_rise) w_state_next = c_ST_IDLE;
                else if (w_enter_rise)           w_state_next = c_ST_COMMIT;
                else if (w_edit_rise)            w_state_next = c_ST_TENS;
            end
            c_ST_TENS: begin
                if (w_edit_rise && w_enter_rise) w_state_next = c_ST_IDLE;
                else if (w_enter_rise)           w_state_next = c_ST_COMMIT;
                else if (w_edit_rise)            w_state_next = c_ST_ONES;
            end
            c_ST_COMMIT: begin
                if (preset_ready) w_state_next = c_ST_IDLE;
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Edge registers, edit data and committed value
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_edit_q    <= 1'b0;
            r_inc_q     <= 1'b0;
            r_dec_q     <= 1'b0;
            r_enter_q   <= 1'b0;
            r_work      <= 8'h00;
            r_committed <= 8'h00;
        end else begin
            r_edit_q  <= edit_btn;
            r_inc_q   <= inc_btn;
            r_dec_q   <= dec_btn;
            r_enter_q <= enter_btn;

            if ((r_state == c_ST_IDLE) && w_edit_rise) begin
                r_work <= r_committed;
            end else if (w_step_inc || w_step_dec) begin
                if (r_state == c_ST_TENS) begin
                    r_work[7:4] <= w_step_inc ? f_bcd_inc(w_sel_nib) : f_bcd_dec(w_sel_nib);
                end else begin
                    r_work[3:0] <= w_step_inc ? f_bcd_inc(w_sel_nib) : f_bcd_dec(w_sel_nib);
                end
            end

            if (w_handshake) begin
                r_committed <= r_work;
            end
        end
    end

    // ------------------------------------------------------------------
    // Auto-repeat counter: cleared on release, both-held, rise or state change
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rpt_cnt   <= '0;
            r_rpt_phase <= 1'b0;
        end else if (!w_in_edit || w_state_chg || !(w_hold_inc || w_hold_dec)) begin
            r_rpt_cnt   <= '0;
            r_rpt_phase <= 1'b0;
        end else if (w_rpt_fire) begin
            r_rpt_cnt   <= '0;
            r_rpt_phase <= 1'b1;
        end else begin
            r_rpt_cnt   <= w_cnt_inc;
        end
    end

    // ------------------------------------------------------------------
    // Blink generator
    // ------------------------------------------------------------------
`ifdef BCD_PRESET_BLINK_EN
    localparam int c_BLK_W = (BLINK_CYCLES < 2) ? 1 : $clog2(BLINK_CYCLES + 1);
    localparam logic [c_BLK_W-1:0] c_BLINK = c_BLK_W'(BLINK_CYCLES);

    logic [c_BLK_W-1:0] r_blk_cnt;
    logic               r_blink;
    logic [c_BLK_W-1:0] w_blk_inc;

    assign w_blk_inc = r_blk_cnt + c_BLK_W'(1);

    // Any step or digit change restarts the phase with the digit shown
    always_ff @(posedge clk) begin
        if (rst) begin
            r_blk_cnt <= '0;
            r_blink   <= 1'b0;
        end else if (!w_in_edit || w_state_chg || w_step_inc || w_step_dec) begin
            r_blk_cnt <= '0;
            r_blink   <= 1'b0;
        end else if (w_blk_inc == c_BLINK) begin
            r_blk_cnt <= '0;
            r_blink   <= ~r_blink;
        end else begin
            r_blk_cnt <= w_blk_inc;
        end
    end
`else
    logic r_blink;
    logic w_unused_blink_cfg;

    assign r_blink            = 1'b0;
    assign w_unused_blink_cfg = (BLINK_CYCLES == 0);
`endif

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        preset       = (r_state == c_ST_IDLE) ? r_committed : r_work;
        preset_valid = (r_state == c_ST_COMMIT);
        editing      = w_in_edit;
        digit_sel    = (r_state == c_ST_TENS);
        blink        = r_blink & w_in_edit;
    end

endmodule
`default_nettype wire

// File: tb/tb_bcd_preset_entry.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_preset_entry
// Purpose  : Directed self-checking bench for bcd_preset_entry
//            (HOLD_CYCLES=4, REPEAT_CYCLES=2, default build without blink).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_preset_entry;

    logic       clk;
    logic       rst;
    logic       edit_btn;
    logic       inc_btn;
    logic       dec_btn;
    logic       enter_btn;
    logic       preset_ready;
    logic [7:0] preset;
    logic       preset_valid;
    logic       editing;
    logic       digit_sel;
    logic       blink;

    int n_checks;
    int n_errors;

    bcd_preset_entry #(
        .HOLD_CYCLES  (4),
        .REPEAT_CYCLES(2),
        .BLINK_CYCLES (3)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .edit_btn    (edit_btn),
        .inc_btn     (inc_btn),
        .dec_btn     (dec_btn),
        .enter_btn   (enter_btn),
        .preset_ready(preset_ready),
        .preset      (preset),
        .preset_valid(preset_valid),
        .editing     (editing),
        .digit_sel   (digit_sel),
        .blink       (blink)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // 0=edit, 1=inc, 2=dec, 3=enter: one-cycle high pulse, then one low cycle
    task automatic press(input int which);
        case (which)
            0: edit_btn  = 1'b1;
            1: inc_btn   = 1'b1;
            2: dec_btn   = 1'b1;
            default: enter_btn = 1'b1;
        endcase
        tick();
        edit_btn  = 1'b0;
        inc_btn   = 1'b0;
        dec_btn   = 1'b0;
        enter_btn = 1'b0;
        tick();
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rst          = 1'b1;
        edit_btn     = 1'b0;
        inc_btn      = 1'b0;
        dec_btn      = 1'b0;
        enter_btn    = 1'b0;
        preset_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check_val("rst_preset", preset, 8'h00);
        check_val("rst_valid", {7'd0, preset_valid}, 8'h00);
        check_val("rst_editing", {7'd0, editing}, 8'h00);
        check_val("rst_digit_sel", {7'd0, digit_sel}, 8'h00);
        check_val("rst_blink", {7'd0, blink}, 8'h00);

        // Inc ignored in IDLE
        press(1);
        check_val("idle_inc_ignored", preset, 8'h00);

        // Edit, three incs, enter with ready high
        press(0);
        check_val("edit_editing", {7'd0, editing}, 8'h01);
        check_val("edit_digit_sel", {7'd0, digit_sel}, 8'h00);
        for (int i = 0; i < 3; i++) press(1);
        check_val("inc3_preset", preset, 8'h03);
        preset_ready = 1'b1;
        enter_btn    = 1'b1;
        tick();
        enter_btn = 1'b0;
        check_val("commit1_valid", {7'd0, preset_valid}, 8'h01);
        check_val("commit1_preset", preset, 8'h03);
        tick();
        check_val("commit1_valid_drop", {7'd0, preset_valid}, 8'h00);
        check_val("commit1_committed", preset, 8'h03);
        check_val("commit1_editing", {7'd0, editing}, 8'h00);
        preset_ready = 1'b0;
        tick();

        // Tens digit: 0 -> 9 on dec, no borrow
        press(0);
        press(0);
        check_val("tens_digit_sel", {7'd0, digit_sel}, 8'h01);
        press(2);
        check_val("tens_dec_preset", preset, 8'h93);

        // Enter with ready low: valid and value held
        press(3);
        for (int i = 0; i < 20; i++) begin
            check_val("hold_valid", {7'd0, preset_valid}, 8'h01);
            check_val("hold_preset", preset, 8'h93);
            tick();
        end
        preset_ready = 1'b1;
        tick();
        preset_ready = 1'b0;
        check_val("commit2_valid_drop", {7'd0, preset_valid}, 8'h00);
        check_val("commit2_committed", preset, 8'h93);

        // Ready outside COMMIT has no effect
        preset_ready = 1'b1;
        tick();
        tick();
        check_val("ready_idle_valid", {7'd0, preset_valid}, 8'h00);
        preset_ready = 1'b0;

        // Ones wrap 9 -> 0 without carry into tens
        press(0);
        check_val("reedit_work", preset, 8'h93);
        for (int i = 0; i < 6; i++) press(1);
        check_val("ones_at_9", preset, 8'h99);
        press(1);
        check_val("ones_wrap", preset, 8'h90);

        // Auto-repeat: steps after hold ticks 0, 4, 6, 8
        inc_btn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_val("autorep", preset,
                      8'h91 + 8'((i >= 4) ? 1 : 0) + 8'((i >= 6) ? 1 : 0) + 8'((i >= 8) ? 1 : 0));
        end
        inc_btn = 1'b0;
        tick();
        check_val("autorep_final", preset, 8'h94);

        // Both held: no change
        inc_btn = 1'b1;
        dec_btn = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check_val("both_held", preset, 8'h94);
        inc_btn = 1'b0;
        dec_btn = 1'b0;
        tick();

        // Cancel from EDIT_TENS after a modification
        press(0);
        press(2);
        check_val("cancel_pre", preset, 8'h84);
        edit_btn  = 1'b1;
        enter_btn = 1'b1;
        tick();
        edit_btn  = 1'b0;
        enter_btn = 1'b0;
        check_val("cancel_editing", {7'd0, editing}, 8'h00);
        check_val("cancel_preset", preset, 8'h93);
        check_val("cancel_valid", {7'd0, preset_valid}, 8'h00);
        tick();
        check_val("cancel_valid2", {7'd0, preset_valid}, 8'h00);

        // Reset in COMMIT with ready high: no transfer
        press(0);
        press(1);
        check_val("pre_rst_work", preset, 8'h94);
        enter_btn = 1'b1;
        tick();
        enter_btn = 1'b0;
        check_val("pre_rst_valid", {7'd0, preset_valid}, 8'h01);
        preset_ready = 1'b1;
        rst          = 1'b1;
        tick();
        rst          = 1'b0;
        preset_ready = 1'b0;
        check_val("rst_commit_valid", {7'd0, preset_valid}, 8'h00);
        check_val("rst_commit_preset", preset, 8'h00);
        check_val("rst_commit_editing", {7'd0, editing}, 8'h00);
        tick();
        check_val("rst_commit_after", preset, 8'h00);
        check_val("blink_default", {7'd0, blink}, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
